// File: rtl/signed_div_seq_if.sv
// Request/response bundle for the sequential signed divider.
interface signed_div_seq_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/signed_div_seq.sv
// Multi-cycle signed divider: restoring shift-subtract on operand magnitudes,
// sign fix-up at the end. Truncates toward zero; fixed WIDTH+2 edge latency.
module signed_div_seq #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  signed_div_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_rem;      // partial remainder, one spare bit for the trial subtract
  logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q, r_sign_r, r_dz, r_ov;
  logic             r_busy, r_done, r_dz_o, r_ov_o;
  logic [WIDTH-1:0] r_q_o, r_r_o;

  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   w_shift, w_trial;
  logic [WIDTH-1:0] w_rem_mag;

  // Magnitudes as unsigned WIDTH bits; the most-negative value maps onto 2^(WIDTH-1).
  assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;

  // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
  assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_rem_mag = r_rem[WIDTH-1:0];

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz_o   <= 1'b0;
      r_ov_o   <= 1'b0;
      r_q_o    <= '0;
      r_r_o    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_sign_r <= bus.dividend[WIDTH-1];
            r_quo    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_dz     <= (bus.divisor == '0);
            r_ov     <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
            r_busy   <= 1'b1;
            r_state  <= S_ITER;
          end
        end
        S_ITER: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial;
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift;
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          // A zero divisor yields all-ones quotient whatever the sign; the
          // remainder magnitude already equals |dividend| so the sign fix restores it.
          r_q_o   <= r_dz ? '1 : (r_sign_q ? (~r_quo + 1'b1) : r_quo);
          r_r_o   <= r_sign_r ? (~w_rem_mag + 1'b1) : w_rem_mag;
          r_dz_o  <= r_dz;
          r_ov_o  <= r_ov;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_q_o;
  assign bus.remainder   = r_r_o;
  assign bus.div_by_zero = r_dz_o;
  assign bus.overflow    = r_ov_o;
endmodule

// File: tb/tb_signed_div_seq.sv
// Randomised and directed checks of signed_div_seq against a plain-arithmetic model.
module tb_signed_div_seq;
  localparam int W = 4;
  // Outputs are sampled 1 time unit after each rising edge; with start
  // sampled at edge k, done is first seen after edge k+W+1 (and so is high
  // at edge k+W+2), and busy is seen high after edges k..k+W.
  localparam int LAT  = W + 1;
  localparam int BUSY = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  signed_div_seq_if #(.WIDTH(W)) bus();

  signed_div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: C-style signed division with the two error cases defined explicitly.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      q = a; r = '0; ov = 1'b1;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      q  = iq[W-1:0];
      r  = ir[W-1:0];
    end
  endfunction

  // Launch one division and wait (bounded) for done; operands are scrambled after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    lat  = -1;
    bcnt = int'(bus.busy);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
      bcnt += int'(bus.busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b ov=%b q=%b r=%b want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[7] = '{4'b1010, 4'b0111, 4'b1001, 4'b0101, 4'b0110, 4'b1000, 4'b1000};
    logic [W-1:0] tb[7] = '{4'b0011, 4'b1110, 4'b0010, 4'b0000, 4'b0010, 4'b1111, 4'b0011};
    logic [W-1:0] tq[7] = '{4'b1110, 4'b1101, 4'b1101, 4'b1111, 4'b0011, 4'b1000, 4'b1110};
    logic [W-1:0] tr[7] = '{4'b0000, 4'b0001, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b1110};
    logic         tz[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         to[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bcnt;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], lat, bcnt);
      checks++;
      if (lat !== LAT || bcnt !== BUSY) begin
        errors++;
        $display("FAIL dir%0d_timing got lat=%0d busy_cycles=%0d want %0d/%0d", i, lat, bcnt, LAT, BUSY);
      end
      checks++;
      if (bus.quotient !== tq[i] || bus.remainder !== tr[i] ||
          bus.div_by_zero !== tz[i] || bus.overflow !== to[i]) begin
        errors++;
        $display("FAIL dir%0d_result %b/%b got q=%b r=%b dz=%b ov=%b want q=%b r=%b dz=%b ov=%b",
                 i, ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                 tq[i], tr[i], tz[i], to[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== tq[i] || bus.remainder !== tr[i]) begin
        errors++;
        $display("FAIL dir%0d_after_done got done=%b busy=%b q=%b r=%b want 0/0 held %b/%b",
                 i, bus.done, bus.busy, bus.quotient, bus.remainder, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic ez, eo;
    int lat, bcnt, bad;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = (i % 10 == 0) ? '0 : W'($urandom);
      ref_div(a, b, eq, er, ez, eo);
      do_op(a, b, lat, bcnt);
      checks++;
      if (lat !== LAT || bus.quotient !== eq || bus.remainder !== er ||
          bus.div_by_zero !== ez || bus.overflow !== eo) begin
        errors++;
        bad++;
        if (bad < 6)
          $display("FAIL rand %b/%b got lat=%0d q=%b r=%b dz=%b ov=%b want lat=%0d q=%b r=%b dz=%b ov=%b",
                   a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                   LAT, eq, er, ez, eo);
      end
    end
  endtask

  // start re-asserted mid-flight with other operands, then held through done.
  task automatic test_back_to_back();
    logic [W-1:0] eq, er;
    logic ez, eo;
    int n1, n2;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'b1001; bus.divisor = 4'b0011;   // -7/3
    @(posedge clk); #1;
    bus.dividend = 4'b0110; bus.divisor = 4'b1111;                     // must be ignored
    n1 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin n1 = n; break; end
    end
    ref_div(4'b1001, 4'b0011, eq, er, ez, eo);
    checks++;
    if (n1 !== LAT || bus.quotient !== eq || bus.remainder !== er) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d q=%b r=%b want lat=%0d q=%b r=%b",
               n1, bus.quotient, bus.remainder, LAT, eq, er);
    end
    // start still high in the done cycle: second request accepted at the next edge.
    bus.dividend = 4'b0111; bus.divisor = 4'b0010;                     // 7/2
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got done=%b busy=%b want 0/1", bus.done, bus.busy);
    end
    n2 = -1;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin n2 = n; break; end
    end
    ref_div(4'b0111, 4'b0010, eq, er, ez, eo);
    checks++;
    if (n2 !== W + 2 || bus.quotient !== eq || bus.remainder !== er) begin
      errors++;
      $display("FAIL b2b_second got edges=%0d q=%b r=%b want edges=%0d q=%b r=%b",
               n2, bus.quotient, bus.remainder, W + 2, eq, er);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, seen;
    do_op(4'b1001, 4'b0010, lat, bcnt);                                // leave nonzero results behind
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'b0111; bus.divisor = 4'b0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b q=%b r=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      seen += int'(bus.done) + int'(bus.busy);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abort got done/busy samples=%0d want 0", seen);
    end
    do_op(4'b1111, 4'b0001, lat, bcnt);
    checks++;
    if (lat !== LAT || bus.quotient !== 4'b1111 || bus.remainder !== 4'b0000) begin
      errors++;
      $display("FAIL reset_recover got lat=%0d q=%b r=%b want lat=%0d q=1111 r=0000",
               lat, bus.quotient, bus.remainder, LAT);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/signed_div_seq.md
Name: signed_div_seq

Overview:
- Multi-cycle signed integer divider. Replaces the combinational signed division path with a shift-subtract (restoring) engine driven by an FSM.
- A start/busy/done handshake lets one requester launch a division and collect quotient and remainder after a fixed latency.
- Operands are two's complement. Results truncate toward zero, matching the existing signed division block.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed dividend, captured on accepted start
- divisor  input  WIDTH  signed divisor, captured on accepted start
- busy  output  1  high while a division is in flight
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  signed quotient, held until next done
- remainder  output  WIDTH  signed remainder, held until next done
- div_by_zero  output  1  status of last result, held with results
- overflow  output  1  status of last result, held with results

Behaviour:
- Reset (async assert, sync deassert expected): state=IDLE; busy, done, div_by_zero, overflow=0; quotient, remainder=0; internal registers cleared.
- FSM states IDLE → ITER → FIX → IDLE.
- IDLE:
  - If start=1 at edge k: capture sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Capture magnitudes |dividend| and |divisor| as WIDTH-bit unsigned. The most-negative value maps to 2^(WIDTH-1) unsigned, so no extra bit is needed.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter. Set busy=1 and go to ITER.
- ITER (exactly WIDTH cycles, edges k+1..k+WIDTH), one restoring step per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Counter counts 0..WIDTH-1; leave after the last step.
- FIX (edge k+WIDTH+1):
  - Negate the quotient magnitude if sign_q=1 and the remainder magnitude if sign_r=1.
  - Register quotient and remainder. Pulse done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 edges from the sampling edge. busy is high for WIDTH+1 cycles. Latency is fixed for all operands, including error cases.
- Identity: dividend = quotient*divisor + remainder. |remainder| < |divisor|. The remainder's sign equals the dividend's sign, or it is zero.
- Divide by zero (divisor=0): runs full latency; quotient = all ones; remainder = dividend; div_by_zero=1, overflow=0.
- Overflow (dividend = -2^(WIDTH-1), divisor = -1): quotient = -2^(WIDTH-1) (wraps); remainder=0; overflow=1.
- div_by_zero and overflow clear to 0 on the next done that has no error.
- start while busy=1: ignored. No queueing; operands are not re-captured.
- start=1 in the done cycle: accepted (FSM is in IDLE) and gives back-to-back operation. The held results stay valid until the next done.
- Operand inputs may change freely after the accepting edge.
- Reset mid-operation: immediate abort to the reset values. No done is produced for the aborted request.

Test Plan (WIDTH=4):
- -6/3 (1010/0011), start at edge 0 → done at edge 6; quotient=1110 (-2), remainder=0000; busy high edges 0-5; flags 0.
- 7/-2 (0111/1110) → quotient=1101 (-3), remainder=0001. Then -7/2 (1001/0010) → quotient=1101 (-3), remainder=1111 (-1).
- 5/0 → after 6 edges: div_by_zero=1, quotient=1111, remainder=0101. Next 6/2 → quotient=0011, remainder=0000, div_by_zero cleared.
- -8/-1 (1000/1111) → quotient=1000, remainder=0000, overflow=1. Also -8/3 → quotient=1110 (-2), remainder=1110 (-2), overflow=0.
- Handshake: start re-asserted with different operands during busy → ignored, original result returned. Start held high through the done cycle → second division accepted, its done exactly 6 edges later. done is never wider than 1 cycle.
- Reset: assert rst_n=0 at ITER cycle 2 → all outputs 0 at once, no done. After release, -1/1 → quotient=1111, remainder=0000.
